onehot_step_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a built-in stepping sequencer. It generalises the 3-to-8 enable-gated decoder to 2^SEL_W outputs. It adds a static load mode and a run mode that walks the active output from a start index to the last index. The square-root datapath uses it as its iteration/stage selector: one hot line per stage, advanced once per completed iteration.

---
 rtl/onehot_step_decoder_pkg.sv | 21 ++
 rtl/onehot_step_decoder_if.sv | 34 +++
 rtl/onehot_step_decoder_dec.sv | 19 +
 rtl/onehot_step_decoder.sv | 126 ++++++++++++
 tb/tb_onehot_step_decoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_step_decoder_pkg.sv
// Shared types, defaults and a reference decode helper for onehot_step_decoder.
package onehot_step_decoder_pkg;

    // Sequencer states: IDLE accepts load/start, RUN accepts step/abort.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SEL_W_DEFAULT = 3;
    localparam int OUT_W_DEFAULT = 2 ** SEL_W_DEFAULT;

    // Binary index to one-hot vector at the default width.
    function automatic logic [OUT_W_DEFAULT-1:0] decode(input logic [SEL_W_DEFAULT-1:0] sel);
        logic [OUT_W_DEFAULT-1:0] vec;
        vec = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/onehot_step_decoder_if.sv
// Control/status bundle of onehot_step_decoder. The master drives the
// commands and the select index; the slave (the decoder) returns the
// decoded vector and status.
interface onehot_step_decoder_if
    import onehot_step_decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             en_i;
    logic             load_i;
    logic             start_i;
    logic             step_i;
    logic             abort_i;
    logic [SEL_W-1:0] sel_i;
    logic [OUT_W-1:0] onehot_o;
    logic [SEL_W-1:0] idx_o;
    logic             busy_o;
    logic             last_o;
    logic             done_o;
    logic             err_o;

    modport master (
        output en_i, load_i, start_i, step_i, abort_i, sel_i,
        input  onehot_o, idx_o, busy_o, last_o, done_o, err_o
    );

    modport slave (
        input  en_i, load_i, start_i, step_i, abort_i, sel_i,
        output onehot_o, idx_o, busy_o, last_o, done_o, err_o
    );

endinterface

// File: rtl/onehot_step_decoder_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder with enable,
// the 3-to-8 enable-gated decoder widened to 2**SEL_W outputs.
module onehot_dec #(
    parameter int SEL_W = 3,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    // One comparator per output line.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
            assign onehot[gi] = en & (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/onehot_step_decoder.sv
// onehot_step_decoder: registered binary-to-one-hot decoder with a stepping
// sequencer (load, start/step/abort run, optional wrap).
// Optional macro ONEHOT_STEP_DECODER_CHECK_EN enables the sticky one-hot
// consistency checker driving err_o; without it err_o is tied low.
module onehot_step_decoder
    import onehot_step_decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT,
    parameter bit WRAP  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_step_decoder_if.slave   bus
);

    localparam int               OUT_W    = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = '1;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] idx_reg, idx_next;
    logic [OUT_W-1:0] onehot_reg, onehot_next;
    logic             done_reg, done_next;
    logic [OUT_W-1:0] sel_dec;

    // Decode of the load/start index.
    onehot_dec #(.SEL_W(SEL_W)) u_sel_dec (
        .en     (1'b1),
        .sel    (bus.sel_i),
        .onehot (sel_dec)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            onehot_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            onehot_reg <= onehot_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic; a low enable holds everything and drops done.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        onehot_next = onehot_reg;
        done_next   = 1'b0;
        if (bus.en_i) begin
            case (state_reg)
                IDLE: begin
                    if (bus.start_i) begin
                        idx_next    = bus.sel_i;
                        onehot_next = sel_dec;
                        state_next  = RUN;
                    end else if (bus.load_i) begin
                        idx_next    = bus.sel_i;
                        onehot_next = sel_dec;
                    end
                end
                RUN: begin
                    if (bus.abort_i) begin
                        onehot_next = '0;
                        state_next  = IDLE;
                    end else if (bus.step_i) begin
                        if (idx_reg != IDX_LAST) begin
                            idx_next    = idx_reg + 1'b1;
                            onehot_next = onehot_reg << 1;
                        end else if (WRAP) begin
                            idx_next    = '0;
                            onehot_next = OUT_W'(1);
                        end else begin
                            onehot_next = '0;
                            done_next   = 1'b1;
                            state_next  = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.onehot_o = bus.en_i ? onehot_reg : '0;
    assign bus.idx_o    = idx_reg;
    assign bus.busy_o   = (state_reg == RUN);
    assign bus.last_o   = (state_reg == RUN) && (idx_reg == IDX_LAST);
    assign bus.done_o   = done_reg;

`ifdef ONEHOT_STEP_DECODER_CHECK_EN
    logic [OUT_W-1:0] idx_dec;
    logic             multi_hot;
    logic             run_empty;
    logic             idx_mismatch;
    logic             err_reg;

    // Independent decode of the held index for cross-checking.
    onehot_dec #(.SEL_W(SEL_W)) u_chk_dec (
        .en     (1'b1),
        .sel    (idx_reg),
        .onehot (idx_dec)
    );

    assign multi_hot    = (onehot_reg & (onehot_reg - 1'b1)) != '0;
    assign run_empty    = (state_reg == RUN) && (onehot_reg == '0);
    assign idx_mismatch = (onehot_reg != '0) && (idx_dec != onehot_reg);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (multi_hot || run_empty || idx_mismatch) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err_o = err_reg;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_step_decoder.sv
// Self-checking bench for onehot_step_decoder: a WRAP=0 and a WRAP=1
// instance share the same stimulus and are compared to an index/flag model.
module tb_onehot_step_decoder;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    logic clk;
    logic rst_n;

    logic             drv_en, drv_ld, drv_st, drv_sp, drv_ab;
    logic [SEL_W-1:0] drv_sel;

    onehot_step_decoder_if #(.SEL_W(SEL_W)) ifc0 ();
    onehot_step_decoder_if #(.SEL_W(SEL_W)) ifc1 ();

    assign ifc0.en_i = drv_en;  assign ifc1.en_i = drv_en;
    assign ifc0.load_i = drv_ld;  assign ifc1.load_i = drv_ld;
    assign ifc0.start_i = drv_st;  assign ifc1.start_i = drv_st;
    assign ifc0.step_i = drv_sp;  assign ifc1.step_i = drv_sp;
    assign ifc0.abort_i = drv_ab;  assign ifc1.abort_i = drv_ab;
    assign ifc0.sel_i = drv_sel;  assign ifc1.sel_i = drv_sel;

    onehot_step_decoder #(.SEL_W(SEL_W), .WRAP(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc0.slave)
    );

    onehot_step_decoder #(.SEL_W(SEL_W), .WRAP(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model per instance: active index, whether a line is lit,
    // whether a run is in progress, and the done pulse.
    int m_idx  [2];
    bit m_lit  [2];
    bit m_busy [2];
    bit m_done [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_idx[w] = 0; m_lit[w] = 0; m_busy[w] = 0; m_done[w] = 0;
        end
    endtask

    task automatic model_update(input int w);
        m_done[w] = 0;
        if (!drv_en) return;
        if (!m_busy[w]) begin
            if (drv_st) begin
                m_idx[w] = int'(drv_sel); m_lit[w] = 1; m_busy[w] = 1;
            end else if (drv_ld) begin
                m_idx[w] = int'(drv_sel); m_lit[w] = 1;
            end
        end else begin
            if (drv_ab) begin
                m_lit[w] = 0; m_busy[w] = 0;
            end else if (drv_sp) begin
                if (m_idx[w] < OUT_W - 1) begin
                    m_idx[w] = m_idx[w] + 1;
                end else if (w == 1) begin
                    m_idx[w] = 0;
                end else begin
                    m_lit[w] = 0; m_busy[w] = 0; m_done[w] = 1;
                end
            end
        end
    endtask

    task automatic check_one(input int w, input logic [7:0] oh, input logic [2:0] idx,
                             input logic busy, input logic last, input logic done, input logic err);
        logic [7:0] exp_oh;
        exp_oh = (m_lit[w] && drv_en) ? 8'(1 << m_idx[w]) : 8'h00;
        check_val($sformatf("w%0d_onehot", w), 32'(oh), 32'(exp_oh));
        check_val($sformatf("w%0d_idx", w), 32'(idx), 32'(m_idx[w]));
        check_val($sformatf("w%0d_busy", w), 32'(busy), 32'(m_busy[w]));
        check_val($sformatf("w%0d_last", w), 32'(last), 32'(m_busy[w] && m_idx[w] == OUT_W - 1));
        check_val($sformatf("w%0d_done", w), 32'(done), 32'(m_done[w]));
        check_val($sformatf("w%0d_err", w), 32'(err), 32'(0));
    endtask

    task automatic check_all();
        check_one(0, ifc0.onehot_o, ifc0.idx_o, ifc0.busy_o, ifc0.last_o, ifc0.done_o, ifc0.err_o);
        check_one(1, ifc1.onehot_o, ifc1.idx_o, ifc1.busy_o, ifc1.last_o, ifc1.done_o, ifc1.err_o);
    endtask

    // One transaction: drive, clock, advance model, compare, report.
    task automatic cycle(input bit en, input bit ld, input bit st, input bit sp, input bit ab,
                         input logic [2:0] sel);
        drv_en = en; drv_ld = ld; drv_st = st; drv_sp = sp; drv_ab = ab; drv_sel = sel;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_all();
        $display("cyc en=%0d ld=%0d st=%0d sp=%0d ab=%0d sel=%0d | oh0=%02h idx0=%0d b0=%0d d0=%0d | oh1=%02h idx1=%0d b1=%0d d1=%0d",
                 en, ld, st, sp, ab, sel, ifc0.onehot_o, ifc0.idx_o, ifc0.busy_o, ifc0.done_o,
                 ifc1.onehot_o, ifc1.idx_o, ifc1.busy_o, ifc1.done_o);
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear at once.
    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        check_val({tag, "_oh0"}, 32'(ifc0.onehot_o), 32'(0));
        check_val({tag, "_idx0"}, 32'(ifc0.idx_o), 32'(0));
        check_val({tag, "_busy0"}, 32'(ifc0.busy_o), 32'(0));
        check_val({tag, "_oh1"}, 32'(ifc1.onehot_o), 32'(0));
        check_val({tag, "_busy1"}, 32'(ifc1.busy_o), 32'(0));
        check_val({tag, "_err0"}, 32'(ifc0.err_o), 32'(0));
        $display("async reset %s: oh0=%02h oh1=%02h", tag, ifc0.onehot_o, ifc1.onehot_o);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv_en = 1'b1; drv_ld = 0; drv_st = 0; drv_sp = 0; drv_ab = 0; drv_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #2 rst_n = 1'b1;

        // Static load of index 5.
        cycle(1, 1, 0, 0, 0, 3'd5);
        check_val("load5_oh", 32'(ifc0.onehot_o), 32'h20);

        // Run from 6 to the end; WRAP=1 instance wraps instead.
        cycle(1, 0, 1, 0, 0, 3'd6);
        check_val("run6_oh", 32'(ifc0.onehot_o), 32'h40);
        cycle(1, 0, 0, 1, 0, 3'd0);
        check_val("run7_oh", 32'(ifc0.onehot_o), 32'h80);
        check_val("run7_last", 32'(ifc0.last_o), 32'(1));
        cycle(1, 0, 0, 1, 0, 3'd0);
        check_val("end_oh", 32'(ifc0.onehot_o), 32'h00);
        check_val("end_done", 32'(ifc0.done_o), 32'(1));
        check_val("end_busy", 32'(ifc0.busy_o), 32'(0));
        check_val("wrap_oh", 32'(ifc1.onehot_o), 32'h01);
        cycle(1, 0, 0, 0, 0, 3'd0);
        check_val("done_pulse", 32'(ifc0.done_o), 32'(0));
        cycle(1, 0, 0, 0, 1, 3'd0);

        // Wrap from the last index.
        cycle(1, 0, 1, 0, 0, 3'd7);
        cycle(1, 0, 0, 1, 0, 3'd0);
        check_val("wrap7_idx", 32'(ifc1.idx_o), 32'(0));
        check_val("wrap7_busy", 32'(ifc1.busy_o), 32'(1));
        check_val("wrap7_done", 32'(ifc1.done_o), 32'(0));
        cycle(1, 0, 0, 0, 1, 3'd0);

        // Abort beats step.
        cycle(1, 0, 1, 0, 0, 3'd3);
        cycle(1, 0, 0, 1, 1, 3'd0);
        check_val("abort_oh", 32'(ifc0.onehot_o), 32'h00);

        // Pause with enable low while step is held.
        cycle(1, 0, 1, 0, 0, 3'd2);
        repeat (3) cycle(0, 0, 0, 1, 0, 3'd0);
        check_val("pause_idx", 32'(ifc0.idx_o), 32'(2));
        cycle(1, 0, 0, 0, 0, 3'd0);
        check_val("resume_oh", 32'(ifc0.onehot_o), 32'h04);
        cycle(1, 0, 0, 0, 1, 3'd0);

        // Back-to-back start in the done cycle.
        cycle(1, 0, 1, 0, 0, 3'd6);
        cycle(1, 0, 0, 1, 0, 3'd0);
        cycle(1, 0, 0, 1, 0, 3'd0);
        cycle(1, 0, 1, 0, 0, 3'd1);
        check_val("b2b_oh", 32'(ifc0.onehot_o), 32'h02);
        check_val("b2b_busy", 32'(ifc0.busy_o), 32'(1));

        // Reset in the middle of a run.
        cycle(1, 0, 0, 1, 0, 3'd0);
        async_reset("midrun");
        cycle(1, 0, 0, 0, 0, 3'd0);

`ifdef ONEHOT_STEP_DECODER_CHECK_EN
        // Two-hot register value must raise the sticky error.
        force dut0.onehot_reg = 8'h03;
        @(posedge clk);
        #1;
        release dut0.onehot_reg;
        check_val("chk_err_set", 32'(ifc0.err_o), 32'(1));
        @(posedge clk);
        #1;
        check_val("chk_err_hold", 32'(ifc0.err_o), 32'(1));
        $display("checker: err0=%0d err1=%0d", ifc0.err_o, ifc1.err_o);
        async_reset("chk");
        cycle(1, 0, 0, 0, 0, 3'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
